// File: rtl/uart_pkg.sv
// Shared definitions for the UART blocks.
// Contents: FSM state enum, parity_mode encodings, baud index constants and
// baud_div(), which rounds clk_hz / (rate * os) to the nearest integer.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBrkWait
  } uart_state_e;

  localparam logic [1:0] ParityNone    = 2'd0;
  localparam logic [1:0] ParityOdd     = 2'd1;
  localparam logic [1:0] ParityEven    = 2'd2;
  localparam logic [1:0] ParityNoneAlt = 2'd3;

  localparam logic [2:0] Baud9600   = 3'd0;
  localparam logic [2:0] Baud19200  = 3'd1;
  localparam logic [2:0] Baud38400  = 3'd2;
  localparam logic [2:0] Baud57600  = 3'd3;
  localparam logic [2:0] Baud115200 = 3'd4;

  function automatic int unsigned baud_rate(input logic [2:0] idx);
    int unsigned rate;
    case (idx)
      Baud9600:   rate = 9600;
      Baud19200:  rate = 19200;
      Baud38400:  rate = 38400;
      Baud57600:  rate = 57600;
      Baud115200: rate = 115200;
      default:    rate = 9600;
    endcase
    return rate;
  endfunction

  function automatic int unsigned baud_div(input int unsigned clk_hz, input logic [2:0] idx,
                                           input int unsigned os);
    int unsigned den;
    den = baud_rate(idx) * os;
    return (clk_hz + den / 2) / den;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator.
// Ports: clk_50mhz/rst_n clock and async active-low reset; clear holds the
// counter at 0; div is the divisor; tick pulses for one cycle at count div-1.
module uart_baud_tick #(
  parameter int unsigned DivW = 9
) (
  input  logic            clk_50mhz,
  input  logic            rst_n,
  input  logic            clear,
  input  logic [DivW-1:0] div,
  output logic            tick
);

  logic [DivW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = !clear && (cnt_q == div - DivW'(1));
    cnt_d = cnt_q + DivW'(1);
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver: 5-8 data bits, none/odd/even parity, 1-2 stop bits.
// Inputs: clk_50mhz, rst_n (async, active low), baud/data_bits/parity_mode/stop2
// frame config (captured at frame start), rxd serial line (idle high).
// Outputs: rx_data, one-cycle rx_valid strobe, parity_err/frame_err/break_det for
// the last frame; all hold until the next completion.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk_50mhz,
  input  logic       rst_n,
  input  logic [2:0] baud,
  input  logic [1:0] data_bits,
  input  logic [1:0] parity_mode,
  input  logic       stop2,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       break_det
);

  localparam int unsigned ScW = $clog2(OVERSAMPLE);
  localparam logic [ScW-1:0] ScSampA  = ScW'(OVERSAMPLE / 2 - 1);
  localparam logic [ScW-1:0] ScSampB  = ScW'(OVERSAMPLE / 2);
  localparam logic [ScW-1:0] ScDecide = ScW'(OVERSAMPLE / 2 + 1);
  localparam logic [ScW-1:0] ScLast   = ScW'(OVERSAMPLE - 1);

  localparam int unsigned Div9600   = baud_div(CLK_HZ, Baud9600, OVERSAMPLE);
  localparam int unsigned Div19200  = baud_div(CLK_HZ, Baud19200, OVERSAMPLE);
  localparam int unsigned Div38400  = baud_div(CLK_HZ, Baud38400, OVERSAMPLE);
  localparam int unsigned Div57600  = baud_div(CLK_HZ, Baud57600, OVERSAMPLE);
  localparam int unsigned Div115200 = baud_div(CLK_HZ, Baud115200, OVERSAMPLE);
  localparam int unsigned DivW      = $clog2(Div9600 + 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rxs, rxs_prev_q, rxs_prev_d;
  uart_state_e            state_q, state_d;
  logic [ScW-1:0]         sc_q, sc_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic                   stop_idx_q, stop_idx_d;
  logic [1:0]             samp_q, samp_d;
  logic [7:0]             shift_q, shift_d;
  logic                   perr_q, perr_d, ferr_q, ferr_d, zero_q, zero_d;
  logic [2:0]             cfg_baud_q, cfg_baud_d;
  logic [1:0]             cfg_bits_q, cfg_bits_d, cfg_par_q, cfg_par_d;
  logic                   cfg_stop2_q, cfg_stop2_d;
  logic [7:0]             rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d, parity_err_q, parity_err_d;
  logic                   frame_err_q, frame_err_d, break_det_q, break_det_d;

  logic [DivW-1:0] div;
  logic            tick, tick_clear, dec, wrap, vote, par_en, par_exp, ferr_now, zero_now;
  logic [2:0]      last_bit;

  assign rxs        = sync_q[SYNC_STAGES-1];
  assign tick_clear = (state_q == StIdle) || (state_q == StBrkWait);

  always_comb begin
    case (cfg_baud_q)
      Baud19200:  div = DivW'(Div19200);
      Baud38400:  div = DivW'(Div38400);
      Baud57600:  div = DivW'(Div57600);
      Baud115200: div = DivW'(Div115200);
      default:    div = DivW'(Div9600);
    endcase
  end

  uart_baud_tick #(
    .DivW(DivW)
  ) u_baud_tick (
    .clk_50mhz(clk_50mhz),
    .rst_n    (rst_n),
    .clear    (tick_clear),
    .div      (div),
    .tick     (tick)
  );

  always_comb begin
    dec      = tick && (sc_q == ScDecide);
    wrap     = tick && (sc_q == ScLast);
    // Two stored samples plus the live line value at the decision tick.
    vote     = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs) | (samp_q[1] & rxs);
    par_en   = !((cfg_par_q == ParityNone) || (cfg_par_q == ParityNoneAlt));
    par_exp  = (cfg_par_q == ParityEven) ? ^shift_q : ~^shift_q;
    last_bit = {1'b0, cfg_bits_q} + 3'd4;
    ferr_now = ferr_q | ~vote;
    // Break looks at data, parity and only the first stop bit.
    zero_now = stop_idx_q ? zero_q : (zero_q & ~vote);

    sync_d       = sync_q << 1;
    sync_d[0]    = rxd;
    rxs_prev_d   = rxs;
    state_d      = state_q;
    sc_d         = sc_q;
    bit_cnt_d    = bit_cnt_q;
    stop_idx_d   = stop_idx_q;
    samp_d       = samp_q;
    shift_d      = shift_q;
    perr_d       = perr_q;
    ferr_d       = ferr_q;
    zero_d       = zero_q;
    cfg_baud_d   = cfg_baud_q;
    cfg_bits_d   = cfg_bits_q;
    cfg_par_d    = cfg_par_q;
    cfg_stop2_d  = cfg_stop2_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    break_det_d  = break_det_q;

    if (tick) begin
      sc_d = (sc_q == ScLast) ? '0 : sc_q + ScW'(1);
      if (sc_q == ScSampA) samp_d[0] = rxs;
      if (sc_q == ScSampB) samp_d[1] = rxs;
    end

    unique case (state_q)
      StIdle: begin
        sc_d = '0;
        if (rxs_prev_q && !rxs) begin
          state_d     = StStart;
          cfg_baud_d  = baud;
          cfg_bits_d  = data_bits;
          cfg_par_d   = parity_mode;
          cfg_stop2_d = stop2;
          bit_cnt_d   = '0;
          stop_idx_d  = 1'b0;
          shift_d     = '0;
          perr_d      = 1'b0;
          ferr_d      = 1'b0;
          zero_d      = 1'b1;
        end
      end
      StStart: begin
        if (dec && vote) begin
          state_d = StIdle;
          sc_d    = '0;
        end else if (wrap) begin
          state_d = StData;
        end
      end
      StData: begin
        if (dec) begin
          shift_d[bit_cnt_q] = vote;
          zero_d             = zero_q & ~vote;
        end
        if (wrap) begin
          if (bit_cnt_q == last_bit) state_d = par_en ? StParity : StStop;
          else bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end
      StParity: begin
        if (dec) begin
          perr_d = vote ^ par_exp;
          zero_d = zero_q & ~vote;
        end
        if (wrap) state_d = StStop;
      end
      StStop: begin
        if (dec) begin
          if (!cfg_stop2_q || stop_idx_q) begin
            // Complete at mid-stop so a slightly fast sender's next start is seen.
            rx_valid_d   = 1'b1;
            rx_data_d    = shift_q;
            parity_err_d = perr_q;
            frame_err_d  = ferr_now;
            break_det_d  = zero_now;
            state_d      = zero_now ? StBrkWait : StIdle;
            sc_d         = '0;
          end else begin
            ferr_d = ferr_now;
            zero_d = zero_now;
          end
        end
        if (wrap) stop_idx_d = 1'b1;
      end
      StBrkWait: begin
        if (rxs) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      sync_q       <= '1;
      rxs_prev_q   <= 1'b1;
      state_q      <= StIdle;
      sc_q         <= '0;
      bit_cnt_q    <= '0;
      stop_idx_q   <= 1'b0;
      samp_q       <= '0;
      shift_q      <= '0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      zero_q       <= 1'b0;
      cfg_baud_q   <= '0;
      cfg_bits_q   <= '0;
      cfg_par_q    <= '0;
      cfg_stop2_q  <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      break_det_q  <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      rxs_prev_q   <= rxs_prev_d;
      state_q      <= state_d;
      sc_q         <= sc_d;
      bit_cnt_q    <= bit_cnt_d;
      stop_idx_q   <= stop_idx_d;
      samp_q       <= samp_d;
      shift_q      <= shift_d;
      perr_q       <= perr_d;
      ferr_q       <= ferr_d;
      zero_q       <= zero_d;
      cfg_baud_q   <= cfg_baud_d;
      cfg_bits_q   <= cfg_bits_d;
      cfg_par_q    <= cfg_par_d;
      cfg_stop2_q  <= cfg_stop2_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      break_det_q  <= break_det_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign break_det  = break_det_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param. A reduced CLK_HZ keeps bit times short.
module tb_uart_rx_param;

  localparam int unsigned ClkHz = 5_000_000;
  localparam int          Os    = 16;
  localparam int          Sync  = 2;

  logic       clk_50mhz = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] baud = 3'd4;
  logic [1:0] data_bits = 2'd3;
  logic [1:0] parity_mode = 2'd0;
  logic       stop2 = 1'b0;
  logic       rxd = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, parity_err, frame_err, break_det;

  uart_rx_param #(
    .CLK_HZ     (ClkHz),
    .OVERSAMPLE (Os),
    .SYNC_STAGES(Sync)
  ) dut (
    .clk_50mhz  (clk_50mhz),
    .rst_n      (rst_n),
    .baud       (baud),
    .data_bits  (data_bits),
    .parity_mode(parity_mode),
    .stop2      (stop2),
    .rxd        (rxd),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .break_det  (break_det)
  );

  always #10 clk_50mhz = ~clk_50mhz;

  int cyc = 0;
  always @(posedge clk_50mhz) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       brk;
    int         t_exp;  // expected strobe cycle, -1 if untimed
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  // Divisor straight from the rate table: round(clk / (rate * 16)).
  function automatic int div_of(input logic [2:0] b);
    real rate;
    case (b)
      3'd1: rate = 19200.0;
      3'd2: rate = 38400.0;
      3'd3: rate = 57600.0;
      3'd4: rate = 115200.0;
      default: rate = 9600.0;
    endcase
    return $rtoi(real'(ClkHz) / (rate * Os) + 0.5);
  endfunction

  function automatic int bit_of(input logic [2:0] b);
    return Os * div_of(b);
  endfunction

  task automatic set_cfg(input logic [2:0] b, input logic [1:0] n, input logic [1:0] p,
                         input logic s2);
    baud = b; data_bits = n; parity_mode = p; stop2 = s2;
  endtask

  task automatic idle_bits(input int nbits);
    rxd = 1'b1;
    repeat (nbits * bit_of(baud)) @(negedge clk_50mhz);
  endtask

  // Builds the line waveform for one frame, predicts the result, then drives it.
  task automatic send_frame(input logic [7:0] data, input bit flip_par, input bit stop_low,
                            input int bit_cyc, input bit timed, input bit scramble);
    int n, p, s, ones;
    bit pb;
    bit line[$];
    exp_t e;
    logic [2:0] sv_baud;
    logic [1:0] sv_bits, sv_par;
    logic sv_stop2;
    n = int'(data_bits) + 5;
    p = (parity_mode == 2'd1 || parity_mode == 2'd2) ? 1 : 0;
    s = stop2 ? 2 : 1;
    ones = 0;
    pb = 1'b0;
    line.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      line.push_back(data[i]);
      ones += int'(data[i]);
    end
    if (p == 1) begin
      pb = (parity_mode == 2'd2) ? ones[0] : !ones[0];
      if (flip_par) pb = !pb;
      line.push_back(pb);
    end
    for (int i = 0; i < s; i++) line.push_back(!stop_low);
    e.data  = data & 8'((1 << n) - 1);
    e.perr  = (p == 1) && flip_par;
    e.ferr  = stop_low;
    e.brk   = (ones == 0) && !pb && stop_low;
    // Strobe: sync + edge detect, then the tick that closes sample 9 of the last stop bit.
    e.t_exp = timed ? cyc + Sync + 1 + (Os * (n + p + s) + Os / 2 + 2) * div_of(baud) : -1;
    sb.push_back(e);
    sv_baud = baud; sv_bits = data_bits; sv_par = parity_mode; sv_stop2 = stop2;
    foreach (line[i]) begin
      rxd = line[i];
      if (scramble && i == 1) begin
        set_cfg(3'($urandom), 2'($urandom), 2'($urandom), 1'($urandom));
      end
      repeat (bit_cyc) @(negedge clk_50mhz);
    end
    set_cfg(sv_baud, sv_bits, sv_par, sv_stop2);
    rxd = 1'b1;
  endtask

  // Monitor: every strobe must match the oldest prediction.
  always @(negedge clk_50mhz) begin
    if (rst_n && rx_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_strobe actual=1 required=0 at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rx_data", 32'(rx_data), 32'(e.data));
        check("flags_perr_ferr_brk", {29'd0, parity_err, frame_err, break_det},
              {29'd0, e.perr, e.ferr, e.brk});
        if (e.t_exp >= 0) begin
          checks++;
          if (cyc - e.t_exp > 2 || e.t_exp - cyc > 2) begin
            failures++;
            $display("FAIL strobe_time actual=%0d required=%0d", cyc, e.t_exp);
          end
        end
      end
    end
  end

  initial begin
    repeat (200000) @(posedge clk_50mhz);
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    exp_t bk;
    repeat (3) @(negedge clk_50mhz);
    check("reset_outputs", {23'd0, rx_data, rx_valid, parity_err, frame_err, break_det}, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk_50mhz);

    // 8N1 at 115200, timed.
    set_cfg(3'd4, 2'd3, 2'd0, 1'b0);
    send_frame(8'hA5, 0, 0, bit_of(baud), 1, 0);
    idle_bits(2);

    // 7E2 at 9600: correct parity, then flipped parity.
    set_cfg(3'd0, 2'd2, 2'd2, 1'b1);
    send_frame(8'h3C, 0, 0, bit_of(baud), 1, 0);
    idle_bits(1);
    send_frame(8'h3C, 1, 0, bit_of(baud), 1, 0);
    idle_bits(1);
    check("hold_parity_err", 32'(parity_err), 32'd1);

    // Glitch shorter than half a bit, then a real frame.
    set_cfg(3'd4, 2'd3, 2'd0, 1'b0);
    rxd = 1'b0;
    repeat (5) @(negedge clk_50mhz);
    idle_bits(3);
    send_frame(8'h55, 0, 0, bit_of(baud), 1, 0);
    idle_bits(2);

    // 5N1 with the stop bit low.
    set_cfg(3'd4, 2'd0, 2'd0, 1'b0);
    send_frame(8'h1F, 0, 1, bit_of(baud), 1, 0);
    idle_bits(2);

    // Break: line low for three frame times gives exactly one strobe.
    set_cfg(3'd4, 2'd3, 2'd0, 1'b0);
    bk.data = 8'h00; bk.perr = 1'b0; bk.ferr = 1'b1; bk.brk = 1'b1; bk.t_exp = -1;
    sb.push_back(bk);
    rxd = 1'b0;
    repeat (3 * 10 * bit_of(baud)) @(negedge clk_50mhz);
    idle_bits(2);
    send_frame(8'($urandom), 0, 0, bit_of(baud), 1, 0);
    idle_bits(2);

    // Random configurations; config inputs scrambled mid-frame.
    repeat (8) begin
      set_cfg(3'($urandom_range(2, 4)), 2'($urandom), 2'($urandom), 1'($urandom));
      send_frame(8'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
                 bit_of(baud), 1, 1);
      idle_bits(1);
    end

    // 16 back-to-back bytes at 57600 from a sender running 2% fast.
    set_cfg(3'd3, 2'd3, 2'd0, 1'b0);
    repeat (16) begin
      send_frame(8'($urandom), 0, 0, $rtoi(real'(bit_of(baud)) / 1.02 + 0.5), 0, 0);
    end
    idle_bits(2);

    // Reset in the middle of a byte.
    set_cfg(3'd4, 2'd3, 2'd2, 1'b0);
    send_frame(8'hC3, 1, 0, bit_of(baud), 1, 0);
    idle_bits(2);
    rxd = 1'b0;
    repeat (4 * bit_of(baud)) @(negedge clk_50mhz);
    rst_n = 1'b0;
    #1;
    check("mid_frame_reset_outputs",
          {23'd0, rx_data, rx_valid, parity_err, frame_err, break_det}, 32'd0);
    repeat (3) @(negedge clk_50mhz);
    rxd = 1'b1;
    repeat (3) @(negedge clk_50mhz);
    rst_n = 1'b1;
    idle_bits(2);
    set_cfg(3'd4, 2'd3, 2'd0, 1'b0);
    send_frame(8'($urandom), 0, 0, bit_of(baud), 1, 0);
    idle_bits(3);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
